// File: rtl/cla_pkg.sv
// Purpose: shared sizing helpers and the per-slice pipeline record for the pipelined CLA adder.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package cla_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_GROUP  = 4;
    localparam int DEF_STAGES = 2;

    // Bits handled by one pipeline slice.
    function automatic int slice_w(input int width, input int stages);
        return width / stages;
    endfunction

    // Lookahead groups per slice.
    function automatic int ngroup(input int width, input int stages, input int group);
        return (width / stages) / group;
    endfunction

    localparam int SLICE_W = slice_w(DEF_WIDTH, DEF_STAGES);
    localparam int NGROUP  = ngroup(DEF_WIDTH, DEF_STAGES, DEF_GROUP);

    // One slice register for the default configuration: valid, carry out of the
    // bits already added, the partial sum so far, and the operand bits still to add.
    typedef struct packed {
        logic                 valid;
        logic                 carry;
        logic [DEF_WIDTH-1:0] psum;
        logic [DEF_WIDTH-1:0] pa;
        logic [DEF_WIDTH-1:0] pb;
    } slice_t;

endpackage

// File: rtl/cla_group.sv
// Purpose: combinational GROUP-bit carry-lookahead block (sum, group propagate/generate).
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no state.
// Ports: i_a/i_b operand bits, i_cin carry in, o_sum sum bits, o_p/o_g group propagate/generate.
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] i_a,
    input  logic [GROUP-1:0] i_b,
    input  logic             i_cin,
    output logic [GROUP-1:0] o_sum,
    output logic             o_p,
    output logic             o_g
);

    logic [GROUP-1:0] w_p;
    logic [GROUP-1:0] w_g;
    logic [GROUP-1:0] w_c;

    assign w_p = i_a ^ i_b;
    assign w_g = i_a & i_b;

    // Unrolled by synthesis into flat lookahead equations per bit.
    always_comb begin
        logic c;
        c   = i_cin;
        w_c = '0;
        for (int i = 0; i < GROUP; i++) begin
            w_c[i] = c;
            c      = w_g[i] | (w_p[i] & c);
        end
    end

    // Group generate is independent of i_cin so the next level can look ahead.
    always_comb begin
        logic gg;
        gg = 1'b0;
        for (int i = 0; i < GROUP; i++) begin
            gg = w_g[i] | (w_p[i] & gg);
        end
        o_g = gg;
    end

    assign o_p   = &w_p;
    assign o_sum = w_p ^ w_c;

endmodule

// File: rtl/cla_pipe_adder.sv
// Purpose: WIDTH-bit add/subtract over STAGES registered slices of lookahead groups.
// Latency: STAGES cycles from accept to out_valid; 1 op/cycle peak.
// Backpressure: whole pipe advances when !out_valid || out_ready; in_ready mirrors that.
// Ports: in_valid/in_ready + a, b, cin, op_sub in; out_valid/out_ready + sum, cout, ovf out.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SW = slice_w(WIDTH, STAGES);
    localparam int NG = ngroup(WIDTH, STAGES, GROUP);

    if (WIDTH % (GROUP * STAGES) != 0) begin : g_bad_cfg
        $error("cla_pipe_adder: WIDTH must be a multiple of GROUP*STAGES");
    end

    typedef struct packed {
        logic             valid;
        logic             carry;
        logic [WIDTH-1:0] psum;
        logic [WIDTH-1:0] pa;
        logic [WIDTH-1:0] pb;
    } stage_t;

    stage_t           r_stg [STAGES];
    logic             r_ovf;

    logic             w_adv;
    logic             w_acc;
    logic             w_last_vld;
    logic             w_ovf;
    logic [WIDTH-1:0] w_in_a [STAGES];
    logic [WIDTH-1:0] w_in_b [STAGES];
    logic [WIDTH-1:0] w_in_s [STAGES];
    logic [WIDTH-1:0] w_nsum [STAGES];
    logic             w_in_c [STAGES];
    logic             w_nco  [STAGES];

    assign w_adv    = !r_stg[STAGES-1].valid || out_ready;
    assign in_ready = w_adv;
    assign w_acc    = in_valid && w_adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [NG:0]   w_gc;
        logic [SW-1:0] w_ssum;
        logic [WIDTH-1:0] w_msum;

        if (k == 0) begin : g_src_in
            // Subtraction folds into addition: a + ~b + ~borrow.
            assign w_in_a[k] = a;
            assign w_in_b[k] = op_sub ? ~b : b;
            assign w_in_c[k] = op_sub ? ~cin : cin;
            assign w_in_s[k] = '0;
        end else begin : g_src_reg
            assign w_in_a[k] = r_stg[k-1].pa;
            assign w_in_b[k] = r_stg[k-1].pb;
            assign w_in_c[k] = r_stg[k-1].carry;
            assign w_in_s[k] = r_stg[k-1].psum;
        end

        assign w_gc[0] = w_in_c[k];

        // Second-level lookahead across the groups of this slice.
        for (genvar j = 0; j < NG; j++) begin : g_grp
            logic w_gp;
            logic w_gg;
            cla_group #(.GROUP(GROUP)) u_grp (
                .i_a   (w_in_a[k][k*SW + j*GROUP +: GROUP]),
                .i_b   (w_in_b[k][k*SW + j*GROUP +: GROUP]),
                .i_cin (w_gc[j]),
                .o_sum (w_ssum[j*GROUP +: GROUP]),
                .o_p   (w_gp),
                .o_g   (w_gg)
            );
            assign w_gc[j+1] = w_gg | (w_gp & w_gc[j]);
        end

        always_comb begin
            w_msum              = w_in_s[k];
            w_msum[k*SW +: SW]  = w_ssum;
        end

        assign w_nsum[k] = w_msum;
        assign w_nco[k]  = w_gc[NG];

        if (k == STAGES - 1) begin : g_ovf
            // a^b^sum at the MSB recovers the carry into the MSB.
            assign w_ovf = (w_in_a[k][WIDTH-1] ^ w_in_b[k][WIDTH-1] ^ w_ssum[SW-1]) ^ w_gc[NG];
        end
    end

    if (STAGES == 1) begin : g_lv1
        assign w_last_vld = w_acc;
    end else begin : g_lvn
        assign w_last_vld = r_stg[STAGES-2].valid;
    end

    // Payload loads only with valid data, so idle inputs never disturb state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_stg[k] <= '0;
            end
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            r_stg[0].valid <= w_acc;
            if (w_acc) begin
                r_stg[0].carry <= w_nco[0];
                r_stg[0].psum  <= w_nsum[0];
                r_stg[0].pa    <= w_in_a[0];
                r_stg[0].pb    <= w_in_b[0];
            end
            for (int k = 1; k < STAGES; k++) begin
                r_stg[k].valid <= r_stg[k-1].valid;
                if (r_stg[k-1].valid) begin
                    r_stg[k].carry <= w_nco[k];
                    r_stg[k].psum  <= w_nsum[k];
                    r_stg[k].pa    <= w_in_a[k];
                    r_stg[k].pb    <= w_in_b[k];
                end
            end
            if (w_last_vld) begin
                r_ovf <= w_ovf;
            end
        end
    end

    // Operand bits below the current slice are dead once consumed.
    logic w_unused;
    always_comb begin
        w_unused = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            w_unused = w_unused ^ (^r_stg[k].pa) ^ (^r_stg[k].pb)
                     ^ (^w_in_a[k]) ^ (^w_in_b[k]);
        end
    end

    assign out_valid = r_stg[STAGES-1].valid;
    assign sum       = r_stg[STAGES-1].psum;
    assign cout      = r_stg[STAGES-1].carry;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Purpose: scoreboard bench for cla_pipe_adder with directed 16-bit vectors.
// Latency: expects results STAGES cycles after accept when unstalled.
// Backpressure: exercises out_ready stalls, back-to-back traffic and reset mid-flight.
module tb_cla_pipe_adder;
    import cla_pkg::*;

    localparam int W  = DEF_WIDTH;
    localparam int ST = DEF_STAGES;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         op_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    cla_pipe_adder #(.WIDTH(W), .GROUP(DEF_GROUP), .STAGES(ST)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic         sub;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        int           acc;
        bit           lat;
    } exp_t;

    vec_t vt [10];
    exp_t q [$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_out = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            a      = 16'($urandom);
            b      = 16'($urandom);
            cin    = 1'($urandom);
            op_sub = 1'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    // Holds the beat until in_ready is seen; records the expected result on accept.
    task automatic send(input vec_t v, input bit push, input bit lat);
        bit done;
        done     = 1'b0;
        a        = v.a;
        b        = v.b;
        cin      = v.ci;
        op_sub   = v.sub;
        in_valid = 1'b1;
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
                if (push) q.push_back('{v.s, v.co, v.ov, cyc, lat});
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready stayed 0 for 40 cycles, want 1");
        end
    endtask

    // Monitor: pops and compares on every output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                n_out++;
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got sum %0h, want no output", sum);
                end else begin
                    e = q.pop_front();
                    chk("sum",  32'(sum),  32'(e.s));
                    chk("cout", 32'(cout), 32'(e.co));
                    chk("ovf",  32'(ovf),  32'(e.ov));
                    if (e.lat) chk("latency", 32'(cyc - e.acc), 32'(ST));
                end
            end
        end
    end

    initial begin
        int n0;
        //           a         b         ci    sub   sum       co    ov
        vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vt[3] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vt[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vt[5] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vt[6] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vt[7] = '{16'h5000, 16'h1000, 1'b1, 1'b1, 16'h3FFF, 1'b1, 1'b0};
        vt[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[9] = '{16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};

        // Reset state.
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum",       32'(sum),       32'd0);
        chk("rst_cout",      32'(cout),      32'd0);
        chk("rst_ovf",       32'(ovf),       32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        idle(2);

        // Single op with latency check.
        send(vt[0], 1'b1, 1'b1);
        idle(4);

        // Back-to-back: eight ops, consecutive results.
        for (int i = 0; i < 8; i++) send(vt[i], 1'b1, 1'b1);
        idle(6);

        // Stall with two ops in flight.
        out_ready = 1'b0;
        send(vt[8], 1'b1, 1'b0);
        send(vt[9], 1'b1, 1'b0);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready",  32'(in_ready),  32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_sum",       32'(sum),       32'(vt[8].s));
            chk("stall_ovf",       32'(ovf),       32'(vt[8].ov));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        idle(5);

        // Reset with two ops in flight; neither may emerge afterwards.
        send(vt[5], 1'b0, 1'b0);
        send(vt[6], 1'b0, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum",       32'(sum),       32'd0);
        chk("midrst_cout",      32'(cout),      32'd0);
        chk("midrst_ovf",       32'(ovf),       32'd0);
        n0 = n_out;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(8);
        chk("no_stale_results", 32'(n_out - n0), 32'd0);

        // Recovery after reset.
        send(vt[1], 1'b1, 1'b1);
        idle(2);

        for (int t = 0; t < 50 && q.size() != 0; t++) @(posedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d results pending, want 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
